// File: rtl/addsub_arbiter_if.sv
// Requester/consumer bundle for addsub_arbiter; rsp_ovf exists only when ADDSUB_OVF_FLAG_EN is defined.
interface addsub_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_sub;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_sub;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
`ifdef ADDSUB_OVF_FLAG_EN
  logic             rsp_ovf;
`endif

  // Client side: drives requests and consumes responses.
  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    output req1_valid, req1_a, req1_b, req1_sub,
    output rsp_ready,
    input  req0_ready, req1_ready,
`ifdef ADDSUB_OVF_FLAG_EN
    input  rsp_ovf,
`endif
    input  rsp_valid, rsp_id, rsp_result, rsp_carry
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    input  req1_valid, req1_a, req1_b, req1_sub,
    input  rsp_ready,
    output req0_ready, req1_ready,
`ifdef ADDSUB_OVF_FLAG_EN
    output rsp_ovf,
`endif
    output rsp_valid, rsp_id, rsp_result, rsp_carry
  );
endinterface

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin arbiter around one ripple-carry add/subtract slice.
// Define ADDSUB_OVF_FLAG_EN to add the registered signed-overflow flag rsp_ovf.
module addsub_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  addsub_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_reg;
  logic             rr_ptr_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             sub_reg;
  logic             id_reg;

  logic             rsp_valid_reg;
  logic             rsp_id_reg;
  logic [WIDTH-1:0] rsp_result_reg;
  logic             rsp_carry_reg;
`ifdef ADDSUB_OVF_FLAG_EN
  logic             rsp_ovf_reg;
  logic             ovf_next;
`endif

  logic             grant_any;
  logic             grant_id;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH:0]   carry_chain;

  // With both requesters valid the pointer decides; otherwise the lone valid one wins.
  always_comb begin
    grant_any = bus.req0_valid | bus.req1_valid;
    grant_id  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = rr_ptr_reg;
    end else if (bus.req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Ready is gated by rst_n so it reads low while reset is held.
  assign bus.req0_ready = rst_n && (state_reg == IDLE) && grant_any && !grant_id;
  assign bus.req1_ready = rst_n && (state_reg == IDLE) && grant_any &&  grant_id;

  assign b_eff          = b_reg ^ {WIDTH{sub_reg}};
  assign carry_chain[0] = sub_reg;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      assign sum_next[gi]      = a_reg[gi] ^ b_eff[gi] ^ carry_chain[gi];
      assign carry_chain[gi+1] = (a_reg[gi] & b_eff[gi]) |
                                 (carry_chain[gi] & (a_reg[gi] ^ b_eff[gi]));
    end
  endgenerate

`ifdef ADDSUB_OVF_FLAG_EN
  assign ovf_next = (a_reg[WIDTH-1] == b_eff[WIDTH-1]) &&
                    (sum_next[WIDTH-1] != a_reg[WIDTH-1]);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= 1'b0;
      a_reg          <= '0;
      b_reg          <= '0;
      sub_reg        <= 1'b0;
      id_reg         <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= 1'b0;
      rsp_result_reg <= '0;
      rsp_carry_reg  <= 1'b0;
`ifdef ADDSUB_OVF_FLAG_EN
      rsp_ovf_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            a_reg     <= grant_id ? bus.req1_a   : bus.req0_a;
            b_reg     <= grant_id ? bus.req1_b   : bus.req0_b;
            sub_reg   <= grant_id ? bus.req1_sub : bus.req0_sub;
            id_reg    <= grant_id;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_reg <= sum_next;
          rsp_carry_reg  <= carry_chain[WIDTH];
          rsp_id_reg     <= id_reg;
`ifdef ADDSUB_OVF_FLAG_EN
          rsp_ovf_reg    <= ovf_next;
`endif
          rsp_valid_reg  <= 1'b1;
          state_reg      <= RESP;
        end
        RESP: begin
          // Pointer moves only on a completed handshake, away from the one just served.
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            rr_ptr_reg    <= ~rsp_id_reg;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.rsp_valid  = rsp_valid_reg;
  assign bus.rsp_id     = rsp_id_reg;
  assign bus.rsp_result = rsp_result_reg;
  assign bus.rsp_carry  = rsp_carry_reg;
`ifdef ADDSUB_OVF_FLAG_EN
  assign bus.rsp_ovf    = rsp_ovf_reg;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter (WIDTH=4); checks rsp_ovf when ADDSUB_OVF_FLAG_EN is defined.
module tb_addsub_arbiter;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  addsub_arbiter_if #(.WIDTH(4)) bus ();

  addsub_arbiter #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_reqs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  // One lone-requester operation; starts and ends on a negedge with the DUT idle.
  task automatic run_op(input logic id, input logic [3:0] a, input logic [3:0] b, input logic sub,
                        input logic [3:0] er, input logic ec, input logic eo);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub;
    end
    #1;
    check("op_ready_grant", id ? bus.req1_ready : bus.req0_ready, 1);
    check("op_ready_other", id ? bus.req0_ready : bus.req1_ready, 0);
    @(negedge clk);
    clear_reqs();
    bus.req0_a = ~a; bus.req0_b = ~b; bus.req1_a = ~a; bus.req1_b = ~b;
    #1;
    check("op_exec_valid", bus.rsp_valid, 0);
    check("op_exec_ready", {bus.req0_ready, bus.req1_ready}, 0);
    @(negedge clk);
    check("op_rsp_valid", bus.rsp_valid, 1);
    check("op_rsp_id", bus.rsp_id, id);
    check("op_rsp_result", bus.rsp_result, er);
    check("op_rsp_carry", bus.rsp_carry, ec);
`ifdef ADDSUB_OVF_FLAG_EN
    check("op_rsp_ovf", bus.rsp_ovf, eo);
`endif
    $display("[TB] txn id=%0d a=%0h b=%0h sub=%0d -> result=%0h carry=%0d (exp ovf=%0d)",
             id, a, b, sub, bus.rsp_result, bus.rsp_carry, eo);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    check("op_rsp_drop", bus.rsp_valid, 0);
  endtask

  logic [1:0] order [8];
  int         n_grant;
  int         cnt0;
  int         cnt1;

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_a = 4'h0; bus.req0_b = 4'h0; bus.req0_sub = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req1_a = 4'h0; bus.req1_b = 4'h0; bus.req1_sub = 1'b0;
    bus.rsp_ready = 1'b0;

    // Reset state, with a request pending that must not be readied.
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_rsp_result", bus.rsp_result, 0);
    check("rst_rsp_carry", bus.rsp_carry, 0);
    check("rst_ready", {bus.req0_ready, bus.req1_ready}, 0);
`ifdef ADDSUB_OVF_FLAG_EN
    check("rst_rsp_ovf", bus.rsp_ovf, 0);
`endif
    clear_reqs();
    rst_n = 1'b1;
    @(negedge clk);

    // T1 / T2: basic add and subtract, including borrow.
    run_op(1'b0, 4'd5, 4'd3, 1'b0, 4'h8, 1'b0, 1'b1);
    run_op(1'b1, 4'd5, 4'd3, 1'b1, 4'h2, 1'b1, 1'b0);
    run_op(1'b1, 4'd3, 4'd5, 1'b1, 4'hE, 1'b0, 1'b0);

    // T3: both requesters held valid after reset alternate 0,1,0,1.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 4'd1; bus.req0_b = 4'd2; bus.req0_sub = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 4'd9; bus.req1_b = 4'd4; bus.req1_sub = 1'b1;
    bus.rsp_ready = 1'b1;
    n_grant = 0; cnt0 = 0; cnt1 = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (bus.req0_ready && n_grant < 8) begin order[n_grant] = 2'd0; n_grant++; cnt0++; end
      if (bus.req1_ready && n_grant < 8) begin order[n_grant] = 2'd1; n_grant++; cnt1++; end
      if (bus.rsp_valid && n_grant > 0) begin
        check("rr_rsp_id", bus.rsp_id, order[n_grant-1]);
        check("rr_rsp_result", bus.rsp_result, (order[n_grant-1] == 2'd0) ? 4'd3 : 4'd5);
        $display("[TB] txn id=%0d result=%0h carry=%0d", bus.rsp_id, bus.rsp_result, bus.rsp_carry);
      end
      @(negedge clk);
    end
    clear_reqs();
    check("rr_grant_count", n_grant, 4);
    check("rr_order0", order[0], 0);
    check("rr_order1", order[1], 1);
    check("rr_order2", order[2], 0);
    check("rr_order3", order[3], 1);
    check("rr_cnt0", cnt0, 2);
    check("rr_cnt1", cnt1, 2);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    check("rr_idle_valid", bus.rsp_valid, 0);

    // T4: consumer stalls five cycles in RESP; outputs hold and no request is readied.
    @(negedge clk);
    bus.req1_valid = 1'b1; bus.req1_a = 4'd2; bus.req1_b = 4'd7; bus.req1_sub = 1'b0;
    #1;
    check("stall_ready1", bus.req1_ready, 1);
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_a = 4'd6; bus.req0_b = 4'd6; bus.req0_sub = 1'b1;
    bus.req1_a = 4'd0;
    #1;
    check("stall_exec_ready", {bus.req0_ready, bus.req1_ready}, 0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_valid", bus.rsp_valid, 1);
      check("stall_id", bus.rsp_id, 1);
      check("stall_result", bus.rsp_result, 4'd9);
      check("stall_carry", bus.rsp_carry, 0);
      check("stall_ready", {bus.req0_ready, bus.req1_ready}, 0);
      @(negedge clk);
    end
    $display("[TB] txn id=1 a=2 b=7 sub=0 -> result=%0h after stall", bus.rsp_result);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    check("stall_release_valid", bus.rsp_valid, 0);
    check("stall_next_ready0", bus.req0_ready, 1);
    check("stall_next_ready1", bus.req1_ready, 0);
    @(negedge clk);
    clear_reqs();
    @(negedge clk);
    check("stall_next_id", bus.rsp_id, 0);
    check("stall_next_result", bus.rsp_result, 4'd0);
    check("stall_next_carry", bus.rsp_carry, 1);
    $display("[TB] txn id=0 a=6 b=6 sub=1 -> result=%0h carry=%0d", bus.rsp_result, bus.rsp_carry);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;

    // T5: reset during EXEC discards the operation and resets rr_ptr.
    bus.req0_valid = 1'b1; bus.req0_a = 4'd4; bus.req0_b = 4'd4; bus.req0_sub = 1'b0;
    #1;
    check("arst_ready0", bus.req0_ready, 1);
    @(negedge clk);
    clear_reqs();
    rst_n = 1'b0;
    #1;
    check("arst_valid", bus.rsp_valid, 0);
    check("arst_id", bus.rsp_id, 0);
    check("arst_result", bus.rsp_result, 0);
    check("arst_carry", bus.rsp_carry, 0);
`ifdef ADDSUB_OVF_FLAG_EN
    check("arst_ovf", bus.rsp_ovf, 0);
`endif
    repeat (2) @(negedge clk);
    check("arst_hold_valid", bus.rsp_valid, 0);
    rst_n = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 4'd4; bus.req0_b = 4'd4; bus.req0_sub = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 4'd1; bus.req1_b = 4'd1; bus.req1_sub = 1'b0;
    #1;
    check("arst_rr_ready0", bus.req0_ready, 1);
    check("arst_rr_ready1", bus.req1_ready, 0);
    @(negedge clk);
    clear_reqs();
    @(negedge clk);
    check("arst_next_valid", bus.rsp_valid, 1);
    check("arst_next_id", bus.rsp_id, 0);
    check("arst_next_result", bus.rsp_result, 4'd8);
    check("arst_next_carry", bus.rsp_carry, 0);
`ifdef ADDSUB_OVF_FLAG_EN
    check("arst_next_ovf", bus.rsp_ovf, 1);
`endif
    $display("[TB] txn id=0 a=4 b=4 sub=0 -> result=%0h carry=%0d", bus.rsp_result, bus.rsp_carry);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;

    // T6 and wrap-around boundaries.
    run_op(1'b0, 4'd7, 4'd1, 1'b0, 4'h8, 1'b0, 1'b1);
    run_op(1'b0, 4'd8, 4'd1, 1'b1, 4'h7, 1'b1, 1'b1);
    run_op(1'b1, 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
    run_op(1'b1, 4'h0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
